// File: rtl/regfile_16x64_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_pkg
//  Purpose  : Shared sizes, write-lane encodings and lane-merge helper for
//             the 16 x 64 register bank.
//  Contents : W, NREG, SELW, WR_* lane modes, word_t, lane_merge()
//  Revision : 1.0  initial release
// ============================================================================
package regbank_pkg;

  localparam int W    = 64;
  localparam int NREG = 16;
  localparam int SELW = 4;

  // endwreg lane modes
  localparam logic [1:0] WR_FULL = 2'b00;
  localparam logic [1:0] WR_LO32 = 2'b01;
  localparam logic [1:0] WR_HI32 = 2'b10;
  localparam logic [1:0] WR_LO16 = 2'b11;

  typedef logic [W-1:0]    word_t;
  typedef logic [SELW-1:0] sel_t;

  // Bits set in the mask take the new data, the rest keep the old word.
  function automatic word_t lane_merge(word_t old_word, word_t new_data,
                                       logic [1:0] mode);
    word_t mask;
    case (mode)
      WR_FULL: mask = {W{1'b1}};
      WR_LO32: mask = {{(W-32){1'b0}}, {32{1'b1}}};
      WR_HI32: mask = {{(W-32){1'b1}}, {32{1'b0}}};
      default: mask = {{(W-16){1'b0}}, {16{1'b1}}};
    endcase
    return (old_word & ~mask) | (new_data & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_16x64_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_16x64_if
//  Purpose  : Write/read bus of the register bank.
//  Signals  : regwen, inA, selwreg, endwreg      write port
//             seloutA/B, cnstA/B, enrregA/B      read-port controls
//             outA, outB                          registered read data
//  Modports : master (drives controls, receives data), slave (the bank)
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_16x64_if;
  import regbank_pkg::*;

  logic       regwen;
  word_t      inA;
  sel_t       selwreg;
  logic [1:0] endwreg;
  sel_t       seloutA;
  sel_t       seloutB;
  logic       cnstA;
  logic       cnstB;
  logic       enrregA;
  logic       enrregB;
  word_t      outA;
  word_t      outB;

  modport master (
    output regwen, inA, selwreg, endwreg,
    output seloutA, seloutB, cnstA, cnstB, enrregA, enrregB,
    input  outA, outB
  );

  modport slave (
    input  regwen, inA, selwreg, endwreg,
    input  seloutA, seloutB, cnstA, cnstB, enrregA, enrregB,
    output outA, outB
  );

endinterface
`default_nettype wire

// File: rtl/regfile_16x64_rdport.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_rdport
//  Purpose  : One read port: register select, constant substitution and an
//             enable-gated output register.
//  Ports    : clock, reset     clock / synchronous active-high reset
//             i_mem            current register contents
//             i_sel            read index
//             i_cnst           substitute CONST for the register value
//             i_en             output register load enable
//             o_out            registered read data
//  Revision : 1.0  initial release
// ============================================================================
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter word_t CONST = '0
) (
  input  wire logic  clock,
  input  wire logic  reset,
  input  wire word_t i_mem [NREG],
  input  wire sel_t  i_sel,
  input  wire logic  i_cnst,
  input  wire logic  i_en,
  output word_t      o_out
);

  word_t w_next;
  word_t r_out;

  always_comb begin
    w_next = i_cnst ? CONST : i_mem[i_sel];
  end

  // i_mem is the pre-edge array, so a same-edge write is not visible here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out <= '0;
    end else if (i_en) begin
      r_out <= w_next;
    end
  end

  assign o_out = r_out;

endmodule
`default_nettype wire

// File: rtl/regfile_16x64.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_16x64
//  Purpose  : 16-entry x 64-bit register bank, one lane-masked write port and
//             two registered read ports (ALU operand sources A and B).
//  Ports    : clock            rising-edge clock
//             reset            synchronous active-high reset (clears all)
//             bus (slave)      write port, read controls, outA/outB
//  Params   : CONST_A/CONST_B  value loaded when cnstA/cnstB is asserted
//  Revision : 1.0  initial release
// ============================================================================
module regfile_16x64
  import regbank_pkg::*;
#(
  parameter word_t CONST_A = '0,
  parameter word_t CONST_B = '0
) (
  input  wire logic      clock,
  input  wire logic      reset,
  regfile_16x64_if.slave bus
);

  word_t r_mem [NREG];
  word_t w_out_a;
  word_t w_out_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.regwen) begin
      r_mem[bus.selwreg] <= lane_merge(r_mem[bus.selwreg], bus.inA, bus.endwreg);
    end
  end

  regbank_rdport #(.CONST(CONST_A)) u_rdport_a (
    .clock  (clock),
    .reset  (reset),
    .i_mem  (r_mem),
    .i_sel  (bus.seloutA),
    .i_cnst (bus.cnstA),
    .i_en   (bus.enrregA),
    .o_out  (w_out_a)
  );

  regbank_rdport #(.CONST(CONST_B)) u_rdport_b (
    .clock  (clock),
    .reset  (reset),
    .i_mem  (r_mem),
    .i_sel  (bus.seloutB),
    .i_cnst (bus.cnstB),
    .i_en   (bus.enrregB),
    .o_out  (w_out_b)
  );

  assign bus.outA = w_out_a;
  assign bus.outB = w_out_b;

endmodule
`default_nettype wire

// File: tb/tb_regfile_16x64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_16x64
//  Purpose  : Self-checking bench for regfile_16x64: directed scenarios plus
//             randomized traffic against an array-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_16x64;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_16x64_if bus ();

  regfile_16x64 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: register contents and the two output registers.
  logic [63:0] model [16];
  logic [63:0] exp_a;
  logic [63:0] exp_b;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] merged(input logic [63:0] old_w,
                                         input logic [63:0] d,
                                         input logic [1:0] mode);
    case (mode)
      2'b00:   return d;
      2'b01:   return {old_w[63:32], d[31:0]};
      2'b10:   return {d[63:32], old_w[31:0]};
      default: return {old_w[63:16], d[15:0]};
    endcase
  endfunction

  task automatic idle();
    reset       = 1'b0;
    bus.regwen  = 1'b0;
    bus.inA     = '0;
    bus.selwreg = '0;
    bus.endwreg = 2'b00;
    bus.seloutA = '0;
    bus.seloutB = '0;
    bus.cnstA   = 1'b0;
    bus.cnstB   = 1'b0;
    bus.enrregA = 1'b0;
    bus.enrregB = 1'b0;
  endtask

  // One clock edge: update the model from pre-edge values, then compare.
  task automatic step(input string tag);
    @(posedge clock);
    if (reset) begin
      foreach (model[i]) model[i] = '0;
      exp_a = '0;
      exp_b = '0;
    end else begin
      if (bus.enrregA) exp_a = bus.cnstA ? 64'd0 : model[bus.seloutA];
      if (bus.enrregB) exp_b = bus.cnstB ? 64'd0 : model[bus.seloutB];
      if (bus.regwen)
        model[bus.selwreg] = merged(model[bus.selwreg], bus.inA, bus.endwreg);
    end
    #1;
    check({tag, "_outA"}, bus.outA, exp_a);
    check({tag, "_outB"}, bus.outB, exp_b);
  endtask

  task automatic write(input int idx, input logic [63:0] d, input logic [1:0] m);
    idle();
    bus.regwen  = 1'b1;
    bus.selwreg = idx[3:0];
    bus.inA     = d;
    bus.endwreg = m;
    step("wr");
  endtask

  task automatic read(input int ia, input int ib);
    idle();
    bus.seloutA = ia[3:0];
    bus.seloutB = ib[3:0];
    bus.enrregA = 1'b1;
    bus.enrregB = 1'b1;
    step("rd");
  endtask

  logic [63:0] held;

  initial begin
    foreach (model[i]) model[i] = 'x;
    exp_a = 'x;
    exp_b = 'x;
    idle();
    reset = 1'b1;
    step("init_rst");

    // 1. reset after a nonzero write
    write(9, 64'hDEAD_BEEF_1234_5678, 2'b00);
    idle();
    reset = 1'b1;
    step("rst");
    check("rst_outA", bus.outA, 64'd0);
    for (int i = 0; i < 16; i++) read(i, 15 - i);

    // 2. full writes with immediate and full readback
    for (int i = 0; i < 16; i++) begin
      write(i, 64'hAB00_75AA_0D8A_0380 + 64'(16 * i), 2'b00);
      read(i, i);
      check("full_wr", bus.outA, 64'hAB00_75AA_0D8A_0380 + 64'(16 * i));
    end
    for (int i = 0; i < 16; i++) read(i, (i + 3) % 16);

    // 3. lane writes on reg3
    write(3, '1, 2'b00);
    write(3, '0, 2'b01);
    read(3, 3);
    check("lane_lo32", bus.outA, 64'hFFFF_FFFF_0000_0000);
    write(3, '0, 2'b10);
    read(3, 3);
    check("lane_hi32", bus.outA, 64'h0000_0000_0000_0000);
    write(3, '1, 2'b00);
    write(3, '0, 2'b11);
    read(3, 3);
    check("lane_lo16", bus.outB, 64'hFFFF_FFFF_FFFF_0000);

    // 4. constant substitution and output hold
    read(4, 4);
    held = bus.outB;
    idle();
    bus.cnstA   = 1'b1;
    bus.enrregA = 1'b1;
    bus.seloutA = 4'd4;
    bus.seloutB = 4'd7;
    step("cnst");
    check("cnstA", bus.outA, 64'd0);
    write(4, 64'h5555_AAAA_5555_AAAA, 2'b00);
    idle();
    bus.seloutB = 4'd4;
    step("holdB");
    check("holdB", bus.outB, held);

    // 5. same-edge write/read collision
    write(5, 64'd1, 2'b00);
    idle();
    bus.regwen  = 1'b1;
    bus.selwreg = 4'd5;
    bus.inA     = 64'd2;
    bus.seloutA = 4'd5;
    bus.enrregA = 1'b1;
    step("coll");
    check("coll_old", bus.outA, 64'd1);
    read(5, 5);
    check("coll_new", bus.outA, 64'd2);

    // 6. regwen=0 with toggling data, then reset during a write
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.inA     = (i % 2 == 0) ? '1 : 64'h0123_4567_89AB_CDEF;
      bus.selwreg = 4'd5;
      step("nowr");
    end
    read(5, 5);
    check("nowr", bus.outA, 64'd2);
    idle();
    reset       = 1'b1;
    bus.regwen  = 1'b1;
    bus.selwreg = 4'd7;
    bus.inA     = '1;
    bus.enrregA = 1'b1;
    step("rst_wr");
    read(7, 7);
    check("rst_wr", bus.outA, 64'd0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset       = ($urandom_range(0, 63) == 0);
      bus.regwen  = $urandom_range(0, 1) == 1;
      bus.inA     = {$urandom, $urandom};
      bus.selwreg = 4'($urandom_range(0, 15));
      bus.endwreg = 2'($urandom_range(0, 3));
      bus.seloutA = 4'($urandom_range(0, 15));
      bus.seloutB = ($urandom_range(0, 3) == 0) ? bus.seloutA : 4'($urandom_range(0, 15));
      bus.cnstA   = ($urandom_range(0, 7) == 0);
      bus.cnstB   = ($urandom_range(0, 7) == 0);
      bus.enrregA = ($urandom_range(0, 3) != 0);
      bus.enrregB = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
